serial_add_sub: RTL and testbench

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

---
 rtl/serial_add_sub.sv | 124 ++++++++++++
 tb/tb_serial_add_sub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB first,
// and publishes sum/cout/ovf together with a one-cycle done pulse.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_d;
    logic             done_d;

    logic             bit_s_c;
    logic             carry_c;
    logic             last_c;
    logic             load_c;

    // Full-adder slice on the current LSBs; carry_c on the last bit is the MSB carry-out
    assign bit_s_c = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign last_c  = (cnt_q == CW'(WIDTH - 1));
    // start is only honoured outside RUN so an in-flight operation is never disturbed
    assign load_c  = start && (state_q != RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status decode from the upcoming state so busy/done come straight from flops
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Operand capture and serial shift datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            res_q <= '0;
        end else if (load_c) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            c_q   <= sub;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= carry_c;
            res_q <= {bit_s_c, res_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Result registers: updated only on the final RUN cycle, held otherwise;
    // c_q on that cycle is the carry into the MSB, used for signed overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if ((state_q == RUN) && last_c) begin
            sum  <= {bit_s_c, res_q[WIDTH-1:1]};
            cout <= carry_c;
            ovf  <= c_q ^ carry_c;
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized self-checking bench for serial_add_sub against an arithmetic model.
module tb_serial_add_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks;
    int n_errors;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                            input logic ts);
        int ua, ub, sa, sb, r, sr;
        logic c, o;
        logic [W-1:0] s;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = $signed(ta);
        sb = $signed(tb_v);
        if (!ts) begin
            r  = ua + ub;
            c  = (r > 255);
            sr = sa + sb;
        end else begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end
        s = W'(r & 255);
        o = (sr > 127) || (sr < -128);
        return {o, c, s};
    endfunction

    // One isolated operation; optionally re-pulses start with a=0x11 mid-run
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input bit repulse);
        logic [W+1:0] exp;
        int nb;
        int ndone;
        bit got;
        exp = model(ta, tb_v, ts);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nb++;
                a = W'($urandom);
                b = W'($urandom);
                sub = 1'($urandom);
                start = 1'b0;
                if (repulse && i == 3) begin
                    start = 1'b1;
                    a = 8'h11;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_timeout", 64'(got), 64'd1);
        if (got) begin
            check("busy_cycles", 64'(nb), 64'(W));
            check("busy_in_done", 64'(busy), 64'd0);
            check("sum", 64'(sum), 64'(exp[W-1:0]));
            check("cout", 64'(cout), 64'(exp[W]));
            check("ovf", 64'(ovf), 64'(exp[W+1]));
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_after_done", 64'(busy), 64'd0);
            check("sum_hold", 64'(sum), 64'(exp[W-1:0]));
            if (repulse) begin
                ndone = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (done) ndone++;
                end
                check("repulse_extra_done", 64'(ndone), 64'd0);
            end
        end
    endtask

    logic [W+1:0] q_exp[$];
    logic [W+1:0] e;
    logic [W-1:0] held;
    int           ndone;
    int           last_cyc;
    int           cyc;
    int           results;
    bit           have_held;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner vectors
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h05, 8'h07, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0);

        // start re-pulsed during RUN is ignored
        do_op(8'h22, 8'h33, 1'b0, 1'b1);

        // Reset mid-run aborts the operation and clears outputs immediately
        @(negedge clk);
        a = 8'h22; b = 8'h33; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_sum_stays", 64'(sum), 64'd0);
        do_op(8'h10, 8'h20, 1'b0, 1'b0);

        // Random isolated operations
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Back-to-back with start held high: one result every W+1 cycles
        @(negedge clk);
        cyc = 0;
        last_cyc = 0;
        results = 0;
        have_held = 1'b0;
        held = '0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        q_exp.push_back(model(a, b, sub));
        start = 1'b1;
        for (int i = 0; i < 80 && results < 5; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                results++;
                e = q_exp.pop_front();
                check("b2b_sum", 64'(sum), 64'(e[W-1:0]));
                check("b2b_cout", 64'(cout), 64'(e[W]));
                check("b2b_ovf", 64'(ovf), 64'(e[W+1]));
                check("b2b_period", 64'(cyc - last_cyc), 64'(W + 1));
                last_cyc = cyc;
                held = sum;
                have_held = 1'b1;
                if (results < 5) begin
                    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
                    q_exp.push_back(model(a, b, sub));
                end else begin
                    start = 1'b0;
                end
            end else begin
                if (have_held) check("b2b_hold", 64'(sum), 64'(held));
                check("b2b_busy", 64'(busy), 64'd1);
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            end
        end
        start = 1'b0;
        check("b2b_results", 64'(results), 64'd5);
        @(negedge clk);
        check("b2b_idle", 64'(busy), 64'd0);
        check("b2b_final_hold", 64'(sum), 64'(held));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
